// File: rtl/hi_lo_pkg.sv
// Shared constants for the HI/LO register pair and divider.
// Op codes, FSM encoding and divide latency.
package hi_lo_pkg;

    localparam int DIV_CYCLES = 32;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_WRPAIR = 3'b001;
    localparam logic [2:0] OP_MTHI   = 3'b010;
    localparam logic [2:0] OP_MTLO   = 3'b011;
    localparam logic [2:0] OP_MADD   = 3'b100;
    localparam logic [2:0] OP_MSUB   = 3'b101;
    localparam logic [2:0] OP_DIV    = 3'b110;
    localparam logic [2:0] OP_DIVU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_FIX
    } state_t;

endpackage

// File: rtl/div_seq_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// done marks the cycle whose edge produces the final bit.
module div_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
    // Top bit of trial set means the subtraction went negative: restore.
    assign trial   = shifted - {1'b0, dvsr};
    assign done    = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvsr <= '0;
            q    <= '0;
            rem  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
        end else if (start) begin
            dvsr <= divisor;
            q    <= dividend;
            rem  <= '0;
            cnt  <= '0;
            run  <= 1'b1;
        end else if (run) begin
            if (trial[WIDTH]) begin
                rem <= shifted;
                q   <= {q[WIDTH-2:0], 1'b0};
            end else begin
                rem <= trial;
                q   <= {q[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (done)
                run <= 1'b0;
        end
    end

    assign quotient  = q;
    assign remainder = rem[WIDTH-1:0];

endmodule

// File: rtl/hi_lo_unit.sv
// HI/LO register pair with MADD/MSUB accumulate and iterative DIV/DIVU.
// Hi/Lo change only on single-cycle ops or in the FIX state of a divide.
module hi_lo_unit
    import hi_lo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             OpValid,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] HiIn,
    input  logic [WIDTH-1:0] LoIn,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy
);

    state_t             state, state_nx;
    logic               accept, div_start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_q, neg_r, dz;
    logic [WIDTH-1:0]   q_mag, r_mag, q_fix, r_fix;
    logic               core_done;
    logic [2*WIDTH-1:0] pair, sum, dif;
    logic [WIDTH-1:0]   hi_nx, lo_nx;

    assign accept    = OpValid && !Busy;
    assign div_start = accept && (Op == OP_DIV || Op == OP_DIVU);
    assign a_neg     = (Op == OP_DIV) && A[WIDTH-1];
    assign b_neg     = (Op == OP_DIV) && B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    div_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk       (Clk),
        .rst       (Reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (q_mag),
        .remainder (r_mag),
        .done      (core_done)
    );

    // On divide-by-zero the core leaves |A| as remainder, so r_fix is A.
    assign q_fix = neg_q ? -q_mag : q_mag;
    assign r_fix = neg_r ? -r_mag : r_mag;

    assign pair = {Hi, Lo};
    assign sum  = pair + {HiIn, LoIn};
    assign dif  = pair - {HiIn, LoIn};

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (div_start) state_nx = ST_DIV;
            ST_DIV:  if (core_done) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_nx = Hi;
        lo_nx = Lo;
        if (state == ST_FIX) begin
            hi_nx = r_fix;
            lo_nx = dz ? '1 : q_fix;
        end else if (accept) begin
            unique case (Op)
                OP_WRPAIR: begin
                    hi_nx = HiIn;
                    lo_nx = LoIn;
                end
                OP_MTHI: hi_nx = A;
                OP_MTLO: lo_nx = A;
                OP_MADD: {hi_nx, lo_nx} = sum;
                OP_MSUB: {hi_nx, lo_nx} = dif;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            Busy  <= (state_nx != ST_IDLE);
            Hi    <= hi_nx;
            Lo    <= lo_nx;
            if (div_start) begin
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dz    <= (B == '0);
            end
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
// Scoreboard bench for hi_lo_unit: driver pushes reference results,
// monitor pops them when an accepted op's result becomes visible.
module tb_hi_lo_unit;
    import hi_lo_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        OpValid;
    logic [2:0]  Op;
    logic [31:0] A, B, HiIn, LoIn;
    logic [31:0] Hi, Lo;
    logic        Busy;

    hi_lo_unit #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .OpValid (OpValid),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .HiIn    (HiIn),
        .LoIn    (LoIn),
        .Hi      (Hi),
        .Lo      (Lo),
        .Busy    (Busy)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mhi, mlo;
    int          checks = 0;
    int          errors = 0;
    bit          done_flag = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no end, required end of run");
        $fatal(1, "watchdog");
    end

    function automatic void ref_div(input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q,
                                    output logic [31:0] r);
        int sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic apply_model(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] hin,
                               input logic [31:0] lin, input string nm);
        logic [63:0] p;
        logic [31:0] q, r;
        exp_t e;
        p = {mhi, mlo};
        case (op)
            OP_WRPAIR: p = {hin, lin};
            OP_MTHI:   p = {a, mlo};
            OP_MTLO:   p = {mhi, a};
            OP_MADD:   p = p + {hin, lin};
            OP_MSUB:   p = p - {hin, lin};
            OP_DIV, OP_DIVU: begin
                ref_div(op == OP_DIV, a, b, q, r);
                p = {r, q};
            end
            default: ;
        endcase
        {mhi, mlo} = p;
        if (op != OP_NOP) begin
            e.hi = mhi;
            e.lo = mlo;
            e.name = nm;
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Called at posedge+2; holds the op until an edge with Busy low takes it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hin,
                         input logic [31:0] lin, input string nm);
        bit   acc;
        logic bs;
        acc = 0;
        OpValid = 1'b1;
        Op = op;
        A = a;
        B = b;
        HiIn = hin;
        LoIn = lin;
        for (int i = 0; i < 100 && !acc; i++) begin
            #6;
            bs = Busy;
            @(posedge Clk);
            #2;
            if (!bs) acc = 1;
        end
        if (!acc) begin
            $display("FAIL accept_%s: op not accepted in 100 cycles, Busy=%0b required 0", nm, Busy);
            $fatal(1, "accept timeout");
        end
        apply_model(op, a, b, hin, lin, nm);
        OpValid = 1'b0;
        A = $urandom;
        B = $urandom;
        HiIn = $urandom;
        LoIn = $urandom;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s_pop: got result with empty queue, required pending entry", tag);
        end else begin
            e = expq.pop_front();
            chk({e.name, "_hi"}, Hi, e.hi);
            chk({e.name, "_lo"}, Lo, e.lo);
        end
    endtask

    always begin : monitor
        bit acc_s, is_div;
        bit divp;
        int bcnt;
        @(posedge Clk);
        acc_s  = !Reset && OpValid && !Busy && (Op != OP_NOP);
        is_div = (Op == OP_DIV) || (Op == OP_DIVU);
        @(negedge Clk);
        if (Reset) begin
            chk("rst_busy", {31'b0, Busy}, 32'd0);
            chk("rst_hi", Hi, 32'd0);
            chk("rst_lo", Lo, 32'd0);
            expq.delete();
            divp = 0;
        end else begin
            if (acc_s && !is_div) begin
                chk("single_busy", {31'b0, Busy}, 32'd0);
                pop_cmp("single");
            end
            if (acc_s && is_div) begin
                chk("div_busy_rise", {31'b0, Busy}, 32'd1);
                divp = 1;
                bcnt = 0;
            end
            if (divp) begin
                if (Busy) begin
                    bcnt++;
                    if (bcnt > 40) begin
                        chk("div_busy_len", bcnt, 33);
                        divp = 0;
                    end
                end else begin
                    chk("div_busy_len", bcnt, 33);
                    pop_cmp("div");
                    divp = 0;
                end
            end
        end
        if (done_flag) begin
            chk("queue_empty", expq.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin : driver
        logic [2:0]  op;
        logic [31:0] a, b;
        Reset = 1'b1;
        OpValid = 1'b0;
        Op = OP_NOP;
        A = 0;
        B = 0;
        HiIn = 0;
        LoIn = 0;
        mhi = 0;
        mlo = 0;
        repeat (2) @(posedge Clk);
        #3 Reset = 1'b0;
        idle(1);

        issue(OP_WRPAIR, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, "wrpair");
        issue(OP_WRPAIR, 0, 0, 32'h0, 32'hFFFF_FFFF, "wrpair2");
        issue(OP_MADD, 0, 0, 32'h0, 32'h1, "madd_carry");
        issue(OP_MSUB, 0, 0, 32'h0, 32'h1, "msub_borrow");
        issue(OP_MTHI, 32'h55, 0, 0, 0, "mthi");
        issue(OP_MTLO, 32'h66, 0, 0, 0, "mtlo");
        issue(OP_DIV, -32'sd7, 32'd2, 0, 0, "div_m7_2");
        issue(OP_DIVU, 32'd7, 32'd2, 0, 0, "divu_7_2");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
        issue(OP_DIVU, 32'd5, 32'd0, 0, 0, "divu_dz");
        issue(OP_DIV, -32'sd9, 32'd0, 0, 0, "div_dz_neg");

        issue(OP_DIV, 32'd1000, 32'd7, 0, 0, "div_hold");
        idle(9);
        issue(OP_MTHI, 32'hAA, 0, 0, 0, "mthi_held");

        issue(OP_DIV, 32'd12345, 32'd3, 0, 0, "div_abort");
        idle(19);
        #1 Reset = 1'b1;
        mhi = 0;
        mlo = 0;
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        issue(OP_DIV, -32'sd100, 32'd7, 0, 0, "div_after_rst");

        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(op, a, b, $urandom, $urandom, "rand");
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end
        idle(40);
        done_flag = 1;
    end

endmodule
